// File: rtl/uart_rx_param_pkg.sv
// Shared constants, FSM state encoding and helpers for the parametrised UART receiver.
package uart_rx_param_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_CLK_DIV    = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick generator: one-clk pulse every CLK_DIV clks.
// Shared by the parametrised UART receiver and transmitter.
module uart_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                 cnt_q <= '0;
    else if (cnt_q == CNT_LAST) cnt_q <= '0;
    else                       cnt_q <= cnt_q + 1'b1;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling, false-start and break detection.
// o_valid rises 1 clk after the last stop-bit decision; a frame finishing while o_valid & !i_ready is dropped (o_overrun).
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = PARITY_EVEN,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int SYNC_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  output logic                  o_break,
  output logic                  o_busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_WIDTH + 1);
  localparam int M   = OVERSAMPLE / 2;

  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SC_PRE  = SCW'(M - 1);
  localparam logic [SCW-1:0] SC_MID  = SCW'(M);
  localparam logic [SCW-1:0] SC_DEC  = SCW'(M + 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic           STOP_LAST = (STOP_BITS == 2);
  localparam logic           ODD_PAR   = (PARITY_MODE == PARITY_ODD);

  // Synchroniser resets to idle-high so reset never looks like a start bit.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  logic tick;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  rx_state_t             state_q, state_n;
  logic [SCW-1:0]        sc_q, sc_n;
  logic [IW-1:0]         idx_q, idx_n;
  logic                  stop_q, stop_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [1:0]            samp_q, samp_n;
  logic                  perr_q, perr_n;
  logic                  ferr_q, ferr_n;
  logic                  seen_q, seen_n;

  logic vote, at_dec, at_end, par_exp;
  logic frame_done, brk_det, frame_ferr;

  always_comb begin
    state_n    = state_q;
    sc_n       = sc_q;
    idx_n      = idx_q;
    stop_n     = stop_q;
    data_n     = data_q;
    samp_n     = samp_q;
    perr_n     = perr_q;
    ferr_n     = ferr_q;
    seen_n     = seen_q;
    frame_done = 1'b0;
    brk_det    = 1'b0;
    vote       = maj3(samp_q[0], samp_q[1], rx_s);
    frame_ferr = ferr_q | ~vote;
    par_exp    = (^data_q) ^ ODD_PAR;
    at_dec     = tick && (sc_q == SC_DEC);
    at_end     = tick && (sc_q == SC_LAST);

    if (tick && state_q != ST_IDLE && state_q != ST_BREAK_WAIT) begin
      sc_n = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
      if (sc_q == SC_PRE) samp_n[0] = rx_s;
      if (sc_q == SC_MID) samp_n[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick && !rx_s) begin
          state_n = ST_START;
          sc_n    = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
          seen_n  = 1'b0;
        end
      end
      ST_START: begin
        if (at_dec && vote) begin
          state_n = ST_IDLE;
        end else if (at_end) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (at_dec) begin
          for (int i = 0; i < DATA_WIDTH; i++)
            if (idx_q == IW'(i)) data_n[i] = vote;
          seen_n = seen_q | vote;
        end
        if (at_end) begin
          if (idx_q == IDX_LAST) begin
            state_n = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
            stop_n  = 1'b0;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (at_dec) begin
          seen_n = seen_q | vote;
          if (vote != par_exp) perr_n = 1'b1;
        end
        if (at_end) begin
          state_n = ST_STOP;
          stop_n  = 1'b0;
        end
      end
      ST_STOP: begin
        if (at_dec) begin
          if (!vote) ferr_n = 1'b1;
          seen_n = seen_q | vote;
          // Frame ends at mid-bit of the last stop bit so a back-to-back start edge is not missed.
          if (stop_q == STOP_LAST) begin
            if (!(seen_q | vote)) begin
              brk_det = 1'b1;
              state_n = ST_BREAK_WAIT;
            end else begin
              frame_done = 1'b1;
              state_n    = ST_IDLE;
            end
          end
        end else if (at_end) begin
          stop_n = 1'b1;
        end
      end
      ST_BREAK_WAIT: begin
        if (tick && rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      samp_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sc_q    <= sc_n;
      idx_q   <= idx_n;
      stop_q  <= stop_n;
      data_q  <= data_n;
      samp_q  <= samp_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
      seen_q  <= seen_n;
    end
  end

  // Output holding register: the held word has priority over a new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      o_break   <= brk_det;
      if (frame_done) begin
        if (!o_valid || i_ready) begin
          o_data       <= data_q;
          o_parity_err <= perr_q;
          o_frame_err  <= frame_ferr;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised and directed bench for uart_rx_param against a frame-level reference model.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       i_ready;
  logic       rdy_force;
  logic       rdy_rnd;
  logic       rdy_rand;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_overrun, o_break, o_busy;

  always #5 clk = ~clk;

  assign i_ready = rdy_rand ? rdy_rnd : rdy_force;

  uart_rx_param #(
    .DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1),
    .OVERSAMPLE(16), .CLK_DIV(4), .SYNC_STAGES(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_break      (o_break),
    .o_busy       (o_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what a receiver must report for a frame of given wire bits.
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   brk_seen = 0, ovr_seen = 0, exp_brk = 0, exp_ovr = 0;

  task automatic model(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    if (d == 8'h00 && !p && !s) begin
      exp_brk++;
    end else begin
      e.d  = d;
      e.pe = (p != ^d);
      e.fe = !s;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_break)   brk_seen++;
      if (o_overrun) ovr_seen++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rx_data", {24'd0, o_data}, {24'd0, mon_e.d});
          chk("rx_parity_err", {31'd0, o_parity_err}, {31'd0, mon_e.pe});
          chk("rx_frame_err", {31'd0, o_frame_err}, {31'd0, mon_e.fe});
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    rdy_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    serial_in = 1'b1;
  endtask

  task automatic send_model(input logic [7:0] d, input logic p, input logic s);
    model(d, p, s);
    send_frame(d, p, s);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_valid"},  {31'd0, o_valid}, 32'd0);
    chk({pfx, "_data"},   {24'd0, o_data}, 32'd0);
    chk({pfx, "_perr"},   {31'd0, o_parity_err}, 32'd0);
    chk({pfx, "_ferr"},   {31'd0, o_frame_err}, 32'd0);
    chk({pfx, "_ovr"},    {31'd0, o_overrun}, 32'd0);
    chk({pfx, "_brk"},    {31'd0, o_break}, 32'd0);
    chk({pfx, "_busy"},   {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] d;
    logic       p, s;

    serial_in = 1'b1;
    rdy_force = 1'b1;
    rdy_rand  = 1'b0;
    reset     = 1'b1;
    clks(3);
    chk_all_zero("reset");
    reset = 1'b0;
    clks(BIT_CLKS);

    // Clean frame.
    send_model(8'hA5, 1'b0, 1'b1);
    clks(BIT_CLKS);
    chk("a5_busy_idle", {31'd0, o_busy}, 32'd0);
    chk("a5_consumed", exp_q.size(), 32'd0);

    // Parity error, then frame error followed by a clean frame.
    send_model(8'h3C, 1'b1, 1'b1);
    clks(BIT_CLKS);
    send_model(8'h81, 1'b0, 1'b0);
    clks(2 * BIT_CLKS);
    send_model(8'h7E, 1'b0, 1'b1);
    clks(BIT_CLKS);

    // False start: three ticks of low.
    serial_in = 1'b0;
    clks(12);
    serial_in = 1'b1;
    clks(BIT_CLKS);
    chk("false_start_busy", {31'd0, o_busy}, 32'd0);
    chk("false_start_queue", exp_q.size(), 32'd0);

    // Overrun: consumer stalled across two back-to-back frames.
    rdy_force = 1'b0;
    send_model(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    exp_ovr++;
    clks(16);
    chk("ovr_valid_held", {31'd0, o_valid}, 32'd1);
    chk("ovr_data_held", {24'd0, o_data}, 32'h11);
    chk("ovr_pulses", ovr_seen, exp_ovr);
    rdy_force = 1'b1;
    clks(2);
    chk("ovr_valid_drop", {31'd0, o_valid}, 32'd0);
    chk("ovr_consumed", exp_q.size(), 32'd0);

    // Break: line held low for twelve bit periods.
    exp_brk++;
    serial_in = 1'b0;
    clks(12 * BIT_CLKS);
    serial_in = 1'b1;
    clks(2 * BIT_CLKS);
    chk("break_pulses", brk_seen, exp_brk);
    chk("break_no_valid", exp_q.size(), 32'd0);
    send_model(8'h55, 1'b0, 1'b1);
    clks(BIT_CLKS);

    // Reset in the middle of a data bit abandons the frame.
    v = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(v[i]);
    serial_in = v[5];
    clks(BIT_CLKS / 2);
    reset     = 1'b1;
    serial_in = 1'b1;
    clks(2);
    chk_all_zero("midreset");
    reset = 1'b0;
    clks(2 * BIT_CLKS);
    chk("midreset_busy", {31'd0, o_busy}, 32'd0);
    send_model(8'h0F, 1'b0, 1'b1);
    clks(BIT_CLKS);

    // Randomised frames with a random consumer.
    rdy_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) != 0);
      if (d == 8'h00 && !p && !s) s = 1'b1;
      send_model(d, p, s);
      clks($urandom_range(70, 200));
    end
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;
    clks(200);

    chk("final_queue_drained", exp_q.size(), 32'd0);
    chk("final_break_count", brk_seen, exp_brk);
    chk("final_overrun_count", ovr_seen, exp_ovr);
    chk("final_busy", {31'd0, o_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
